uart_frame_loader_ctrl: RTL
===========================

// Module: uart_frame_loader_ctrl
// PURPOSE
//  Sequences the UART RX peripheral into the image buffer: captures each received byte,
//  writes it to sequential buffer addresses and clears the RX "new data" flag.
//  Declares the frame complete after IMG_BYTES bytes and holds it for the LCD engine.
//  Aborts a partial frame on an inter-byte timeout. Sits between uart_rx and the image RAM/LCD path.
// PARAMETERS
//  IMG_BYTES    64800   bytes per frame (sim builds use 5)
//  ADDR_W       16      buffer address width; IMG_BYTES <= 2**ADDR_W
//  TIMEOUT_CYC  281300  idle clk cycles allowed between bytes of a partial frame (~10 byte times @9600/27MHz)
// PORTS
//  clk          in   1       system clock, 27 MHz
//  resetn       in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: arm a new frame
//  abort        in   1       1-cycle pulse: drop frame, go idle
//  release      in   1       1-cycle pulse from LCD engine: buffer consumed
//  rx_new       in   1       uart_rx byte-available flag (level, held until rx_clr)
//  rx_data      in   8       received byte, valid while rx_new=1
//  rx_clr       out  1       1-cycle pulse: clear rx_new
//  mem_we       out  1       buffer write strobe
//  mem_addr     out  ADDR_W  buffer write address
//  mem_wdata    out  8       buffer write data
//  busy         out  1       1 in RECV/WRITE
//  frame_ready  out  1       1 in FULL
//  done         out  1       1-cycle pulse on entering FULL
//  err_timeout  out  1       sticky; 1 in ERR
//  overrun      out  1       sticky; byte arrived outside RECV/WRITE; cleared by start/abort
//  byte_count   out  ADDR_W+1  bytes written in current frame
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; byte_count=0; timer=0. All outputs registered.
//  States: IDLE, RECV, WRITE, FULL, ERR.
//  IDLE: start -> RECV, byte_count=0, timer=0, overrun=0.
//  RECV: rx_new=1 in cycle N -> cycle N+1: mem_we=1, mem_addr=byte_count, mem_wdata=rx_data(N),
//   rx_clr=1, state WRITE. Cycle N+2: byte_count+1; if new count==IMG_BYTES -> FULL with done=1
//   for that cycle, else RECV. uart_rx clears rx_new at edge ending the rx_clr cycle.
//  WRITE: exactly one cycle; rx_new ignored.
//  Timer: runs in RECV only when byte_count>0; cleared on every accepted byte; reaching
//   TIMEOUT_CYC -> ERR, err_timeout=1. byte_count=0 never times out (waits forever for first byte).
//  FULL: frame_ready=1; buffer frozen (mem_we=0). release -> IDLE; start -> RECV (new frame).
//  ERR: holds byte_count; start -> RECV (clears err_timeout); release ignored.
//  rx_new=1 in IDLE/FULL/ERR: rx_clr pulsed next cycle, byte dropped, overrun=1.
//  Priority same cycle: abort > start > rx byte accept > timeout. abort from any state -> IDLE,
//   clears err_timeout/overrun, no mem_we; if abort hits WRITE the write already issued stands.
//  start while busy: ignored. Byte accepted in same cycle timer hits limit: byte wins, timer cleared.
//  Address never wraps: last write at IMG_BYTES-1; byte_count saturates at IMG_BYTES.
//  resetn low mid-frame: immediate return to reset values; no further writes.
// TESTING (IMG_BYTES=5, TIMEOUT_CYC=100)
//  1 start, send 0x11,0x22,0x33,0x44,0x55 -> writes addr0..4 in order, 5 rx_clr pulses, done 1 cycle, frame_ready=1, byte_count=5.
//  2 in FULL send 0xAA -> rx_clr pulse, no mem_we, overrun=1; release -> IDLE, frame_ready=0.
//  3 start, send 2 bytes, idle 100 cycles -> ERR, err_timeout=1, byte_count=2; start -> RECV, byte_count=0.
//  4 start, idle 1000 cycles with no byte -> stays RECV, no error.
//  5 abort after 3rd byte -> IDLE, busy=0, no further writes; next start restarts at addr0.
//  6 resetn low during WRITE -> all outputs 0 immediately; rx_new held high after reset in IDLE -> overrun only, no write.

Source files
------------

// File: rtl/uart_frame_loader_ctrl.sv
// uart_frame_loader_ctrl: moves uart_rx bytes into the image buffer,
// flags frame completion and drops partial frames on inter-byte timeout.
module uart_frame_loader_ctrl #(
  parameter int unsigned IMG_BYTES   = 64800,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 281300
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              buf_release,
  input  logic              rx_new,
  input  logic [7:0]        rx_data,
  output logic              rx_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              frame_ready,
  output logic              done,
  output logic              err_timeout,
  output logic              overrun,
  output logic [ADDR_W:0]   byte_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] FRAME_LEN =
    (ADDR_W + 1)'(IMG_BYTES);
  localparam logic [TW-1:0] TIME_LIM =
    TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_FULL,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_n;
  logic [ADDR_W:0]   cnt_n;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_n;
  logic              we_n;
  logic              clr_n;
  logic              done_n;
  logic              ovr_n;
  logic              rx_hit;
  logic              in_frame;

  // rx_new stays high through our own rx_clr cycle; ignore it there
  assign rx_hit   = rx_new & ~rx_clr;
  assign in_frame = (state == S_RECV) || (state == S_WRITE);
  assign cnt_inc  = byte_count + 1'b1;

  always_comb begin
    state_n = state;
    timer_n = timer;
    cnt_n   = byte_count;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    ovr_n   = overrun;
    we_n    = 1'b0;
    clr_n   = 1'b0;
    done_n  = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
      ovr_n   = 1'b0;
    end else if (start && !in_frame) begin
      state_n = S_RECV;
      cnt_n   = '0;
      timer_n = '0;
      ovr_n   = 1'b0;
    end else begin
      unique case (state)
        S_RECV: begin
          if (rx_hit) begin
            state_n = S_WRITE;
            we_n    = 1'b1;
            clr_n   = 1'b1;
            addr_n  = byte_count[ADDR_W-1:0];
            wdata_n = rx_data;
            timer_n = '0;
          end else if (byte_count != '0) begin
            if (timer == TIME_LIM) begin
              state_n = S_ERR;
            end else begin
              timer_n = timer + 1'b1;
            end
          end
        end
        S_WRITE: begin
          cnt_n = cnt_inc;
          if (cnt_inc == FRAME_LEN) begin
            state_n = S_FULL;
            done_n  = 1'b1;
          end else begin
            state_n = S_RECV;
          end
        end
        S_IDLE, S_FULL, S_ERR: begin
          if (rx_hit) begin
            clr_n = 1'b1;
            ovr_n = 1'b1;
          end
          if (state == S_FULL && buf_release) begin
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      timer       <= '0;
      byte_count  <= '0;
      rx_clr      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      byte_count  <= cnt_n;
      rx_clr      <= clr_n;
      mem_we      <= we_n;
      mem_addr    <= addr_n;
      mem_wdata   <= wdata_n;
      busy        <= (state_n == S_RECV) ||
                     (state_n == S_WRITE);
      frame_ready <= (state_n == S_FULL);
      done        <= done_n;
      err_timeout <= (state_n == S_ERR);
      overrun     <= ovr_n;
    end
  end

endmodule
